// File: rtl/vrf_read_pipe_pkg.sv
// Shared types and widths for the VRF read pipe. Record layouts follow the default configuration.
package vrf_read_pipe_pkg;

  localparam int unsigned DEF_NUM_CH   = 2;
  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_VS_W     = 5;
  localparam int unsigned DEF_OFFSET_W = 2;
  localparam int unsigned DEF_SRC_W    = 2;
  localparam int unsigned DEF_IDX_W    = 3;
  localparam int unsigned DEF_READ_LAT = 2;
  localparam int unsigned DEF_QDEPTH   = 4;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned CH_W   = clog2_min1(DEF_NUM_CH);
  localparam int unsigned CRED_W = $clog2(DEF_QDEPTH + 1);

  typedef struct packed {
    logic [DEF_VS_W-1:0]     vs;
    logic [DEF_OFFSET_W-1:0] offset;
    logic [DEF_SRC_W-1:0]    src;
    logic [DEF_IDX_W-1:0]    idx;
  } read_req_t;

  typedef struct packed {
    logic            valid;
    logic [CH_W-1:0] ch;
  } tag_t;

endpackage

// File: rtl/vrf_read_sync_fifo.sv
// Show-ahead synchronous FIFO holding returned read data for one channel.
module vrf_read_sync_fifo
  import vrf_read_pipe_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned QDEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop_ready,
  output logic              pop_valid,
  output logic [DATA_W-1:0] pop_data
);

  localparam int unsigned PTR_W = clog2_min1(QDEPTH);
  localparam int unsigned CNT_W = $clog2(QDEPTH + 1);

  logic [DATA_W-1:0] r_mem [QDEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_empty, w_full, w_push, w_pop;

  assign w_empty = (r_cnt == '0);
  assign w_full  = (r_cnt == CNT_W'(QDEPTH));
  assign w_pop   = pop_ready & ~w_empty;
  assign w_push  = push_valid & (~w_full | w_pop);

  assign pop_valid = ~w_empty;
  assign pop_data  = w_empty ? '0 : r_mem[r_rptr];

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wptr] <= push_data;
  end

  // Explicit wrap so non-power-of-two depths work.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PTR_W'(QDEPTH - 1)) ? '0 : r_wptr + 1'b1;
      if (w_pop)  r_rptr <= (r_rptr == PTR_W'(QDEPTH - 1)) ? '0 : r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/vrf_read_pipe_mc.sv
// N-channel VRF read front end: credit-gated round-robin, fixed-latency tag pipe, per-channel FIFOs.
// Optional performance counters are built when VRF_READ_PIPE_PERF_EN is defined.
module vrf_read_pipe_mc
  import vrf_read_pipe_pkg::*;
#(
  parameter int unsigned NUM_CH   = DEF_NUM_CH,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned VS_W     = DEF_VS_W,
  parameter int unsigned OFFSET_W = DEF_OFFSET_W,
  parameter int unsigned SRC_W    = DEF_SRC_W,
  parameter int unsigned IDX_W    = DEF_IDX_W,
  parameter int unsigned READ_LAT = DEF_READ_LAT,
  parameter int unsigned QDEPTH   = DEF_QDEPTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_CH-1:0]            req_valid,
  output logic [NUM_CH-1:0]            req_ready,
  input  logic [NUM_CH*VS_W-1:0]       req_vs,
  input  logic [NUM_CH*OFFSET_W-1:0]   req_offset,
  input  logic [NUM_CH*SRC_W-1:0]      req_src,
  input  logic [NUM_CH*IDX_W-1:0]      req_idx,
  output logic                         vrf_req_valid,
  input  logic                         vrf_req_ready,
  output logic [VS_W-1:0]              vrf_req_vs,
  output logic [OFFSET_W-1:0]          vrf_req_offset,
  output logic [SRC_W-1:0]             vrf_req_src,
  output logic [IDX_W-1:0]             vrf_req_idx,
  input  logic [DATA_W-1:0]            vrf_rdata,
  output logic [NUM_CH-1:0]            deq_valid,
  input  logic [NUM_CH-1:0]            deq_ready,
  output logic [NUM_CH*DATA_W-1:0]     deq_data
`ifdef VRF_READ_PIPE_PERF_EN
  ,
  output logic [31:0]                  perf_stall_cnt,
  output logic [31:0]                  perf_grant_cnt
`endif
);

  read_req_t         w_req [NUM_CH];
  read_req_t         w_sel;
  logic [CRED_W-1:0] r_credit [NUM_CH];
  logic [CH_W-1:0]   r_ptr, w_gnt_idx;
  tag_t              r_tag [READ_LAT];
  logic [NUM_CH-1:0] w_cred_ok, w_elig, w_grant, w_push, w_fifo_valid, w_deq_fire;
  logic [NUM_CH*DATA_W-1:0] w_fifo_data;
  logic              w_any, w_fire;
  int                w_c;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_req[i] = '{vs:     req_vs[i*VS_W +: VS_W],
                   offset: req_offset[i*OFFSET_W +: OFFSET_W],
                   src:    req_src[i*SRC_W +: SRC_W],
                   idx:    req_idx[i*IDX_W +: IDX_W]};
      w_cred_ok[i] = (r_credit[i] != '0);
    end
  end

  assign w_elig = req_valid & w_cred_ok & {NUM_CH{~reset}};

  // Search begins one past the last granted channel.
  always_comb begin
    w_grant   = '0;
    w_gnt_idx = '0;
    w_any     = 1'b0;
    w_c       = 0;
    for (int k = 1; k <= int'(NUM_CH); k++) begin
      w_c = int'(r_ptr) + k;
      if (w_c >= int'(NUM_CH)) w_c = w_c - int'(NUM_CH);
      if (!w_any && w_elig[w_c]) begin
        w_any        = 1'b1;
        w_gnt_idx    = CH_W'(w_c);
        w_grant[w_c] = 1'b1;
      end
    end
  end

  always_comb begin
    w_sel = '0;
    if (w_any) w_sel = w_req[w_gnt_idx];
  end

  assign w_fire         = w_any & vrf_req_ready;
  assign vrf_req_valid  = w_any;
  assign req_ready      = w_grant & {NUM_CH{vrf_req_ready}};
  assign vrf_req_vs     = w_sel.vs;
  assign vrf_req_offset = w_sel.offset;
  assign vrf_req_src    = w_sel.src;
  assign vrf_req_idx    = w_sel.idx;

  assign deq_valid  = w_fifo_valid & {NUM_CH{~reset}};
  assign deq_data   = reset ? '0 : w_fifo_data;
  assign w_deq_fire = deq_valid & deq_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr <= CH_W'(NUM_CH - 1);
      for (int i = 0; i < NUM_CH; i++) r_credit[i] <= CRED_W'(QDEPTH);
    end else begin
      if (w_fire) r_ptr <= w_gnt_idx;
      for (int i = 0; i < NUM_CH; i++) begin
        unique case ({req_ready[i], w_deq_fire[i]})
          2'b10:   r_credit[i] <= r_credit[i] - 1'b1;
          2'b01:   r_credit[i] <= r_credit[i] + 1'b1;
          default: r_credit[i] <= r_credit[i];
        endcase
      end
    end
  end

  // Last stage lines up with vrf_rdata of the matching request.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < READ_LAT; s++) r_tag[s] <= '0;
    end else begin
      r_tag[0] <= '{valid: w_fire, ch: w_gnt_idx};
      for (int s = 1; s < READ_LAT; s++) r_tag[s] <= r_tag[s-1];
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_push[i] = r_tag[READ_LAT-1].valid && (r_tag[READ_LAT-1].ch == CH_W'(i));
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_fifo
    vrf_read_sync_fifo #(
      .DATA_W (DATA_W),
      .QDEPTH (QDEPTH)
    ) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push_valid (w_push[g]),
      .push_data  (vrf_rdata),
      .pop_ready  (deq_ready[g] & ~reset),
      .pop_valid  (w_fifo_valid[g]),
      .pop_data   (w_fifo_data[g*DATA_W +: DATA_W])
    );
  end

`ifdef VRF_READ_PIPE_PERF_EN
  logic [31:0] r_stall_cnt, r_grant_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_grant_cnt <= '0;
    end else begin
      if (|(req_valid & ~w_cred_ok) && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_fire && (r_grant_cnt != '1)) r_grant_cnt <= r_grant_cnt + 1'b1;
    end
  end

  assign perf_stall_cnt = r_stall_cnt;
  assign perf_grant_cnt = r_grant_cnt;
`else
  // Counters are compiled out; nothing further to drive.
`endif

endmodule
